// File: rtl/arith_pkg.sv
// Shared arithmetic-library definitions: sequencer state encoding and default width.
package arith_pkg;

    localparam int ARITH_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor built from two cascaded half-subtractor stages.
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    logic hs1_d_s;
    logic hs1_b_s;
    logic hs2_b_s;

    // First stage subtracts b from a; second stage subtracts the incoming borrow.
    assign hs1_d_s = a ^ b;
    assign hs1_b_s = ~a & b;
    assign d       = hs1_d_s ^ bin;
    assign hs2_b_s = ~hs1_d_s & bin;
    assign bout    = hs1_b_s | hs2_b_s;

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial LSB-first unsigned subtractor: one full-subtractor cell, WIDTH cycles per result.
module serial_subtractor
    import arith_pkg::*;
#(
    parameter int WIDTH = ARITH_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out,
    output logic             zero
);

    localparam int             CW       = $clog2(WIDTH);
    localparam logic [CW-1:0]  CNT_LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0]  CNT_ONE  = CW'(1);

    state_e           state_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] res_q;
    logic [WIDTH-1:0] res_d;
    logic             borrow_q;
    logic [CW-1:0]    cnt_q;
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] diff_q;
    logic             borrow_out_q;
    logic             zero_q;
    logic             fs_d_s;
    logic             fs_bout_s;

    full_subtractor u_fs (
        .a    (a_q[0]),
        .b    (b_q[0]),
        .bin  (borrow_q),
        .d    (fs_d_s),
        .bout (fs_bout_s)
    );

    // New bit enters at the MSB so that after WIDTH shifts bit 0 sits at the LSB.
    assign res_d = {fs_d_s, res_q[WIDTH-1:1]};

    // Sequencer, serial datapath and result registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            a_q          <= '0;
            b_q          <= '0;
            res_q        <= '0;
            borrow_q     <= 1'b0;
            cnt_q        <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            diff_q       <= '0;
            borrow_out_q <= 1'b0;
            zero_q       <= 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        a_q      <= a;
                        b_q      <= b;
                        res_q    <= '0;
                        borrow_q <= 1'b0;
                        cnt_q    <= '0;
                        busy_q   <= 1'b1;
                        state_q  <= RUN;
                    end else begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                RUN: begin
                    a_q      <= {1'b0, a_q[WIDTH-1:1]};
                    b_q      <= {1'b0, b_q[WIDTH-1:1]};
                    res_q    <= res_d;
                    borrow_q <= fs_bout_s;
                    cnt_q    <= cnt_q + CNT_ONE;
                    if (cnt_q == CNT_LAST) begin
                        diff_q       <= res_d;
                        borrow_out_q <= fs_bout_s;
                        zero_q       <= (res_d == '0);
                        done_q       <= 1'b1;
                        busy_q       <= 1'b0;
                        state_q      <= DONE;
                    end else begin
                        done_q <= 1'b0;
                        busy_q <= 1'b1;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign diff       = diff_q;
    assign borrow_out = borrow_out_q;
    assign zero       = zero_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed self-checking bench for serial_subtractor at WIDTH=8 and exhaustive WIDTH=4.
module tb_serial_subtractor;

    logic       clk;
    logic       rst8;
    logic       start8;
    logic [7:0] a8;
    logic [7:0] b8;
    logic       busy8;
    logic       done8;
    logic [7:0] diff8;
    logic       borrow8;
    logic       zero8;

    logic       rst4;
    logic       start4;
    logic [3:0] a4;
    logic [3:0] b4;
    logic       busy4;
    logic       done4;
    logic [3:0] diff4;
    logic       borrow4;
    logic       zero4;

    int checks;
    int errors;

    serial_subtractor #(.WIDTH(8)) dut8 (
        .clk        (clk),
        .rst        (rst8),
        .start      (start8),
        .a          (a8),
        .b          (b8),
        .busy       (busy8),
        .done       (done8),
        .diff       (diff8),
        .borrow_out (borrow8),
        .zero       (zero8)
    );

    serial_subtractor #(.WIDTH(4)) dut4 (
        .clk        (clk),
        .rst        (rst4),
        .start      (start4),
        .a          (a4),
        .b          (b4),
        .busy       (busy4),
        .done       (done4),
        .diff       (diff4),
        .borrow_out (borrow4),
        .zero       (zero4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Waits (bounded) for done8; returns busy cycles seen before it.
    task automatic wait_done8(output int nbusy, output bit got);
        nbusy = 0;
        got   = 1'b0;
        for (int i = 0; i < 30 && !got; i++) begin
            if (done8) got = 1'b1;
            else begin
                if (busy8) nbusy++;
                @(negedge clk);
            end
        end
    endtask

    task automatic op8(input logic [7:0] av, input logic [7:0] bv,
                       input logic [7:0] ed, input logic eb, input logic ez);
        int nb;
        bit got;
        a8 = av; b8 = bv; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        wait_done8(nb, got);
        check_value("done8_seen", 32'(got), 32'd1);
        check_value("busy8_cycles", 32'(nb), 32'd8);
        check_value("diff8", 32'(diff8), 32'(ed));
        check_value("borrow8", 32'(borrow8), 32'(eb));
        check_value("zero8", 32'(zero8), 32'(ez));
        @(negedge clk);
        check_value("done8_width", 32'(done8), 32'd0);
        check_value("diff8_hold", 32'(diff8), 32'(ed));
    endtask

    initial begin
        int  nb;
        int  gap;
        bit  got;
        bit  busy_seen;
        logic [4:0] full;
        checks = 0; errors = 0;
        rst8 = 1'b1; rst4 = 1'b1; start8 = 1'b0; start4 = 1'b0;
        a8 = 8'h00; b8 = 8'h00; a4 = 4'h0; b4 = 4'h0;
        @(negedge clk);
        @(negedge clk);
        rst8 = 1'b0; rst4 = 1'b0;

        check_value("rst_outs8", {27'd0, busy8, done8, borrow8, zero8, |diff8}, 32'd0);
        check_value("rst_outs4", {27'd0, busy4, done4, borrow4, zero4, |diff4}, 32'd0);
        busy_seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            busy_seen = busy_seen | busy8 | done8;
        end
        check_value("idle_quiet", 32'(busy_seen), 32'd0);

        op8(8'h35, 8'h12, 8'h23, 1'b0, 1'b0);
        op8(8'h12, 8'h35, 8'hDD, 1'b1, 1'b0);
        op8(8'h00, 8'h01, 8'hFF, 1'b1, 1'b0);
        op8(8'h7A, 8'h7A, 8'h00, 1'b0, 1'b1);
        op8(8'h00, 8'hFF, 8'h01, 1'b1, 1'b0);

        // Start held high; operands change during RUN.
        a8 = 8'h35; b8 = 8'h12; start8 = 1'b1;
        @(negedge clk);
        @(negedge clk);
        a8 = 8'hFF; b8 = 8'h00;
        wait_done8(nb, got);
        check_value("b2b_done1", 32'(got), 32'd1);
        check_value("b2b_diff1", 32'(diff8), 32'h23);
        gap = 0; got = 1'b0;
        for (int i = 0; i < 30 && !got; i++) begin
            @(negedge clk);
            gap++;
            if (done8) got = 1'b1;
        end
        start8 = 1'b0;
        check_value("b2b_done2", 32'(got), 32'd1);
        check_value("b2b_gap", 32'(gap), 32'd9);
        check_value("b2b_diff2", 32'(diff8), 32'hFF);
        check_value("b2b_borrow2", 32'(borrow8), 32'd0);
        @(negedge clk);
        check_value("b2b_idle", 32'(busy8), 32'd0);

        // Asynchronous reset in the middle of a RUN.
        a8 = 8'h35; b8 = 8'h12; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        for (int i = 0; i < 4; i++) @(negedge clk);
        check_value("pre_rst_busy", 32'(busy8), 32'd1);
        #2;
        rst8 = 1'b1;
        #1;
        check_value("async_rst", {27'd0, busy8, done8, borrow8, zero8, |diff8}, 32'd0);
        @(negedge clk);
        rst8 = 1'b0;
        op8(8'h80, 8'h01, 8'h7F, 1'b0, 1'b0);

        // Exhaustive 4-bit sweep.
        for (int ia = 0; ia < 16; ia++) begin
            for (int ib = 0; ib < 16; ib++) begin
                a4 = 4'(ia); b4 = 4'(ib); start4 = 1'b1;
                @(negedge clk);
                start4 = 1'b0;
                got = 1'b0;
                for (int i = 0; i < 12 && !got; i++) begin
                    if (done4) got = 1'b1;
                    else @(negedge clk);
                end
                full = {1'b0, 4'(ia)} - {1'b0, 4'(ib)};
                check_value("w4_done", 32'(got), 32'd1);
                check_value("w4_diff", 32'(diff4), 32'(full[3:0]));
                check_value("w4_borrow", 32'(borrow4), 32'(ia < ib));
                check_value("w4_zero", 32'(zero4), 32'(ia == ib));
                @(negedge clk);
                check_value("w4_done_width", 32'(done4), 32'd0);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
